// File: rtl/adf4002_pkg.sv
// Shared types and SPI master register map for the ADF4002 word sequencer.
package adf4002_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSelWr,
    StSsoOn,
    StPollTrdy,
    StDataWr,
    StPollTmt,
    StSsoOff,
    StStatClr,
    StGap
  } seq_state_e;

  typedef enum logic [1:0] {
    AccIdle,
    AccAct1,
    AccAct2
  } acc_phase_e;

  localparam logic [2:0] ADDR_RXDATA   = 3'd0;
  localparam logic [2:0] ADDR_TXDATA   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;
  localparam logic [2:0] ADDR_SLAVESEL = 3'd5;

  localparam int unsigned STAT_TRDY = 6;
  localparam int unsigned STAT_TMT  = 5;

  localparam logic [15:0] CTRL_SSO   = 16'h0400;
  localparam logic [15:0] SLAVE_SEL0 = 16'h0001;

  // Byte b of a 24-bit latch word, b = 2 is the MSB byte.
  function automatic logic [7:0] word_byte(input logic [23:0] word, input logic [1:0] b);
    logic [7:0] res;
    unique case (b)
      2'd2:    res = word[23:16];
      2'd1:    res = word[15:8];
      default: res = word[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adf4002_spi_acc.sv
// Single-access engine for the SPI master control port: 2 strobe cycles then 1 idle cycle.
module adf4002_spi_acc
  import adf4002_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        is_read_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] data_to_cpu_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        spi_select_o,
  output logic [2:0]  mem_addr_o,
  output logic        write_n_o,
  output logic        read_n_o,
  output logic [15:0] data_from_cpu_o
);

  acc_phase_e  phase_q, phase_d;
  logic        sel_q, sel_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= AccIdle;
      sel_q   <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    sel_d   = sel_q;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (phase_q)
      AccIdle: begin
        if (req_i) begin
          phase_d = AccAct1;
          sel_d   = 1'b1;
          wr_n_d  = is_read_i;
          rd_n_d  = ~is_read_i;
          addr_d  = addr_i;
          data_d  = wdata_i;
        end
      end
      AccAct1: phase_d = AccAct2;
      AccAct2: begin
        phase_d = AccIdle;
        sel_d   = 1'b0;
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
      default: phase_d = AccIdle;
    endcase
  end

  // done marks the 2nd active cycle; the caller samples rdata on that clock edge, which lets
  // the next request land in the idle cycle and keeps accesses at 3 cycles each.
  assign done_o          = (phase_q == AccAct2);
  assign busy_o          = (phase_q != AccIdle);
  assign rdata_o         = data_to_cpu_i;
  assign spi_select_o    = sel_q;
  assign mem_addr_o      = addr_q;
  assign write_n_o       = wr_n_q;
  assign read_n_o        = rd_n_q;
  assign data_from_cpu_o = data_q;

endmodule

// File: rtl/adf4002_spi_seq.sv
// Sends 24-bit ADF4002 latch words as three MSB-first bytes under one slave-select,
// with an optional four-word initialisation sequence after reset.
module adf4002_spi_seq
  import adf4002_pkg::*;
#(
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [23:0] INIT_W0    = 24'h000093,
  parameter logic [23:0] INIT_W1    = 24'h000092,
  parameter logic [23:0] INIT_W2    = 24'h000010,
  parameter logic [23:0] INIT_W3    = 24'h000101,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_data,
  output logic        cmd_ready,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        write_n,
  output logic        read_n,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu
);

  localparam int unsigned PollW = ($clog2(POLL_LIMIT + 1) > 10) ? $clog2(POLL_LIMIT + 1) : 10;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 2);
  localparam int unsigned PollLastInt = (POLL_LIMIT > 0) ? POLL_LIMIT - 1 : 0;
  localparam int unsigned GapLastInt  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [PollW-1:0] PollLast = PollLastInt[PollW-1:0];
  localparam logic [GapW-1:0]  GapLast  = GapLastInt[GapW-1:0];

  seq_state_e       state_q, state_d;
  logic [23:0]      word_q, word_d;
  logic [1:0]       byte_q, byte_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             in_init_q, in_init_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic             cmd_ready_q;

  logic        acc_active, acc_req, acc_rd, acc_busy, acc_done;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata;
  logic [23:0] init_word;
  logic        unused_rdata;

  assign unused_rdata = ^{acc_rdata[15:7], acc_rdata[4:0]};

  always_comb begin
    unique case (init_idx_q)
      2'd0:    init_word = INIT_W0;
      2'd1:    init_word = INIT_W1;
      2'd2:    init_word = INIT_W2;
      default: init_word = INIT_W3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT_EN ? StLoad : StIdle;
      word_q      <= '0;
      byte_q      <= 2'd2;
      poll_q      <= '0;
      gap_q       <= '0;
      init_idx_q  <= 2'd0;
      in_init_q   <= INIT_EN;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      init_idx_q  <= init_idx_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == StIdle);
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_d      = byte_q;
    poll_d      = poll_q;
    gap_d       = gap_q;
    init_idx_d  = init_idx_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q | ~INIT_EN;
    err_d       = err_q;
    acc_active  = 1'b0;
    acc_rd      = 1'b0;
    acc_addr    = ADDR_RXDATA;
    acc_wdata   = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          word_d  = cmd_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (in_init_q) word_d = init_word;
        byte_d  = 2'd2;
        state_d = StSelWr;
      end
      StSelWr: begin
        acc_active = 1'b1;
        acc_addr   = ADDR_SLAVESEL;
        acc_wdata  = SLAVE_SEL0;
        if (acc_done) state_d = StSsoOn;
      end
      StSsoOn: begin
        acc_active = 1'b1;
        acc_addr   = ADDR_CONTROL;
        acc_wdata  = CTRL_SSO;
        if (acc_done) begin
          poll_d  = '0;
          state_d = StPollTrdy;
        end
      end
      StPollTrdy: begin
        acc_active = 1'b1;
        acc_rd     = 1'b1;
        acc_addr   = ADDR_STATUS;
        if (acc_done) begin
          if (acc_rdata[STAT_TRDY]) begin
            state_d = StDataWr;
          end else if (poll_q >= PollLast) begin
            // Timeout drops the rest of the word but still closes the frame cleanly.
            err_d   = 1'b1;
            state_d = StSsoOff;
          end else begin
            poll_d = poll_q + PollW'(1);
          end
        end
      end
      StDataWr: begin
        acc_active = 1'b1;
        acc_addr   = ADDR_TXDATA;
        acc_wdata  = {8'h00, word_byte(word_q, byte_q)};
        if (acc_done) begin
          poll_d = '0;
          if (byte_q == 2'd0) begin
            state_d = StPollTmt;
          end else begin
            byte_d  = byte_q - 2'd1;
            state_d = StPollTrdy;
          end
        end
      end
      StPollTmt: begin
        acc_active = 1'b1;
        acc_rd     = 1'b1;
        acc_addr   = ADDR_STATUS;
        if (acc_done) begin
          if (acc_rdata[STAT_TMT]) begin
            state_d = StSsoOff;
          end else if (poll_q >= PollLast) begin
            err_d   = 1'b1;
            state_d = StSsoOff;
          end else begin
            poll_d = poll_q + PollW'(1);
          end
        end
      end
      StSsoOff: begin
        acc_active = 1'b1;
        acc_addr   = ADDR_CONTROL;
        acc_wdata  = 16'h0000;
        if (acc_done) state_d = StStatClr;
      end
      StStatClr: begin
        acc_active = 1'b1;
        acc_addr   = ADDR_STATUS;
        acc_wdata  = 16'h0000;
        if (acc_done) begin
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q >= GapLast) begin
          if (in_init_q) begin
            if (init_idx_q == 2'd3) begin
              in_init_d   = 1'b0;
              init_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              state_d    = StLoad;
            end
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign acc_req = acc_active & ~acc_busy;

  adf4002_spi_acc u_acc (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_i           (acc_req),
    .is_read_i       (acc_rd),
    .addr_i          (acc_addr),
    .wdata_i         (acc_wdata),
    .data_to_cpu_i   (data_to_cpu),
    .busy_o          (acc_busy),
    .done_o          (acc_done),
    .rdata_o         (acc_rdata),
    .spi_select_o    (spi_select),
    .mem_addr_o      (mem_addr),
    .write_n_o       (write_n),
    .read_n_o        (read_n),
    .data_from_cpu_o (data_from_cpu)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != StIdle);
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adf4002_spi_seq.sv
// Bench for adf4002_spi_seq: byte-level SPI master model, frame scoreboard, bus monitor.
module tb_adf4002_spi_seq;

  localparam int PollLim = 15;
  localparam int GapCyc  = 8;

  typedef struct {
    logic [23:0] word;
    int          nbytes;
  } exp_t;

  typedef struct {
    logic [23:0] word;
    int          nbytes;
    int          gap;
    int          reads;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready, busy, init_done, err, spi_select, write_n, read_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;

  logic        cmd_valid2;
  logic [23:0] cmd_data2;
  logic        cmd_ready2, busy2, init_done2, err2, spi_select2, write_n2, read_n2;
  logic [2:0]  mem_addr2;
  logic [15:0] data_from_cpu2;
  logic [15:0] data_to_cpu2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  obs_t obs_q[$];
  logic [18:0] w2_q[$];

  adf4002_spi_seq #(
    .INIT_EN    (1'b1),
    .GAP_CYCLES (GapCyc),
    .POLL_LIMIT (PollLim)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .busy          (busy),
    .init_done     (init_done),
    .err           (err),
    .spi_select    (spi_select),
    .mem_addr      (mem_addr),
    .write_n       (write_n),
    .read_n        (read_n),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu)
  );

  adf4002_spi_seq #(
    .INIT_EN (1'b0)
  ) dut_noinit (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid2),
    .cmd_data      (cmd_data2),
    .cmd_ready     (cmd_ready2),
    .busy          (busy2),
    .init_done     (init_done2),
    .err           (err2),
    .spi_select    (spi_select2),
    .mem_addr      (mem_addr2),
    .write_n       (write_n2),
    .read_n        (read_n2),
    .data_from_cpu (data_from_cpu2),
    .data_to_cpu   (data_to_cpu2)
  );

  // Second instance sees a master that is always ready and empty.
  assign data_to_cpu2 = 16'h0060;

  // ---------------- SPI master model (byte level) ----------------
  logic        m_sso, m_seen, m_hold_trdy, m_trdy, m_tmt;
  logic [23:0] m_frame;
  int          m_nbytes, m_shift, m_ss_high, m_gap, m_reads, m_acc_cyc;

  assign m_trdy = !m_hold_trdy && (m_shift == 0);
  assign m_tmt  = (m_shift == 0);
  // ROE (bit 3) and E (bit 8) are always set to show they are ignored.
  assign data_to_cpu = (mem_addr == 3'd2) ?
                       {7'd0, 1'b1, 1'b0, m_trdy, m_tmt, 1'b0, 1'b1, 3'd0} : 16'h0000;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sso     <= 1'b0;
      m_seen    <= 1'b0;
      m_frame   <= '0;
      m_nbytes  <= 0;
      m_shift   <= 0;
      m_ss_high <= 0;
      m_gap     <= -1;
      m_reads   <= 0;
      m_acc_cyc <= 0;
    end else begin
      if (m_shift > 0) m_shift <= m_shift - 1;
      if (!m_sso) m_ss_high <= m_ss_high + 1;
      m_acc_cyc <= (!write_n || !read_n) ? m_acc_cyc + 1 : 0;
      if (!read_n && m_acc_cyc == 1 && mem_addr == 3'd2) m_reads <= m_reads + 1;
      if (!write_n && m_acc_cyc == 1) begin
        if (mem_addr == 3'd1) begin
          m_frame  <= {m_frame[15:0], data_from_cpu[7:0]};
          m_nbytes <= m_nbytes + 1;
          m_shift  <= 16;
        end else if (mem_addr == 3'd3 && data_from_cpu[10]) begin
          m_sso    <= 1'b1;
          m_gap    <= m_seen ? m_ss_high : -1;
          m_frame  <= '0;
          m_nbytes <= 0;
          m_reads  <= 0;
        end else if (mem_addr == 3'd3 && m_sso) begin
          m_sso     <= 1'b0;
          m_ss_high <= 0;
          m_seen    <= 1'b1;
          obs_q.push_back('{m_frame, m_nbytes, m_gap, m_reads});
        end
      end
    end
  end

  // Bus protocol observer: counts malformed accesses for the tests to inspect.
  int          p_run, p_bad, p_acc;
  logic [2:0]  p_addr;
  logic [15:0] p_data;
  logic        p_wr;
  initial begin
    p_run = 0;
    p_bad = 0;
    p_acc = 0;
  end
  always @(negedge clk) begin
    if (!reset_n) begin
      p_run = 0;
    end else if (!write_n || !read_n) begin
      if (p_run == 0) begin
        p_addr = mem_addr;
        p_data = data_from_cpu;
        p_wr   = !write_n;
      end else if (mem_addr !== p_addr || data_from_cpu !== p_data || (!write_n) !== p_wr) begin
        p_bad = p_bad + 1;
      end
      if (!write_n && !read_n) p_bad = p_bad + 1;
      if (spi_select !== 1'b1) p_bad = p_bad + 1;
      p_run = p_run + 1;
    end else begin
      if (spi_select !== 1'b0) p_bad = p_bad + 1;
      if (p_run != 0) begin
        p_acc = p_acc + 1;
        if (p_run != 2) p_bad = p_bad + 1;
      end
      p_run = 0;
    end
  end

  // Write log for the no-init instance, taken on the 2nd strobe cycle.
  logic w2_prev;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w2_prev <= 1'b0;
    end else begin
      w2_prev <= !write_n2;
      if (!write_n2 && w2_prev) w2_q.push_back({mem_addr2, data_from_cpu2});
    end
  end

  // ---------------- helpers (no comparisons) ----------------
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_word(input logic [23:0] w, output bit ok);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_init;
    exp_q.push_back('{24'h000093, 3});
    exp_q.push_back('{24'h000092, 3});
    exp_q.push_back('{24'h000010, 3});
    exp_q.push_back('{24'h000101, 3});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #12;
    n_checks++;
    if ({cmd_ready, busy, init_done, err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 0100", {cmd_ready, busy, init_done, err});
    end
    n_checks++;
    if ({spi_select, write_n, read_n, mem_addr, data_from_cpu} !== {3'b011, 3'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_bus: got %b/%b/%b/%h/%h, expected 0/1/1/0/0000",
               spi_select, write_n, read_n, mem_addr, data_from_cpu);
    end
    n_checks++;
    if ({cmd_ready2, busy2, init_done2, err2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_noinit: got %b, expected 0000", {cmd_ready2, busy2, init_done2, err2});
    end
  endtask

  task automatic test_init(input string name);
    bit   ok;
    exp_t e;
    obs_t o;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (init_done) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: init_done=%b, expected 1", name, init_done);
    end
    n_checks++;
    if ({cmd_ready, busy, err} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_flags: ready/busy/err=%b, expected 100", name, {cmd_ready, busy, err});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_frame: got none, expected %06h", name, e.word);
      end else begin
        o = obs_q.pop_front();
        if (o.word !== e.word || o.nbytes != e.nbytes) begin
          n_fail++;
          $display("FAIL %s_frame: got %06h/%0d bytes, expected %06h/%0d",
                   name, o.word, o.nbytes, e.word, e.nbytes);
        end
        if (o.gap >= 0) begin
          n_checks++;
          if (o.gap < GapCyc) begin
            n_fail++;
            $display("FAIL %s_gap: got %0d, expected >= %0d", name, o.gap, GapCyc);
          end
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_extra: got %0d extra frames, expected 0", name, obs_q.size());
    end
  endtask

  task automatic test_no_init;
    logic [18:0] exp_w[7];
    logic [18:0] got;
    int          busy_low;
    bit          ok;
    exp_w = '{{3'd5, 16'h0001}, {3'd3, 16'h0400}, {3'd1, 16'h00AB}, {3'd1, 16'h00CD},
              {3'd1, 16'h00EF}, {3'd3, 16'h0000}, {3'd2, 16'h0000}};
    n_checks++;
    if ({init_done2, cmd_ready2, busy2} !== 3'b110) begin
      n_fail++;
      $display("FAIL noinit_idle: done/ready/busy=%b, expected 110", {init_done2, cmd_ready2, busy2});
    end
    w2_q.delete();
    @(negedge clk);
    cmd_valid2 = 1'b1;
    cmd_data2  = 24'hABCDEF;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    busy_low = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ready2) begin
        ok = 1'b1;
        break;
      end
      if (!busy2) busy_low++;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || busy_low != 0) begin
      n_fail++;
      $display("FAIL noinit_busy: done=%b busy_low_cycles=%0d, expected 1/0", ok, busy_low);
    end
    n_checks++;
    if (w2_q.size() != 7) begin
      n_fail++;
      $display("FAIL noinit_nwrites: got %0d, expected 7", w2_q.size());
    end
    for (int i = 0; i < 7 && w2_q.size() > 0; i++) begin
      got = w2_q.pop_front();
      n_checks++;
      if (got !== exp_w[i]) begin
        n_fail++;
        $display("FAIL noinit_write%0d: got a%0d=%04h, expected a%0d=%04h",
                 i, got[18:16], got[15:0], exp_w[i][18:16], exp_w[i][15:0]);
      end
    end
  endtask

  task automatic test_host_words;
    logic [23:0] words[3];
    bit          ok;
    exp_t        e;
    obs_t        o;
    words = '{24'hABCDEF, 24'h5A0F3C, 24'h800001};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{words[i], 3});
      send_word(words[i], ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL host_accept: word %06h not accepted, expected accept", words[i]);
      end
      wait_idle(3000, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL host_idle: ready=%b busy=%b, expected 1/0", cmd_ready, busy);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL host_frame: got none, expected %06h", e.word);
      end else begin
        o = obs_q.pop_front();
        if (o.word !== e.word || o.nbytes != e.nbytes) begin
          n_fail++;
          $display("FAIL host_frame: got %06h/%0d bytes, expected %06h/%0d",
                   o.word, o.nbytes, e.word, e.nbytes);
        end
      end
    end
    n_checks++;
    if (p_bad != 0 || p_acc == 0) begin
      n_fail++;
      $display("FAIL bus_protocol: bad=%0d accesses=%0d, expected 0/>0", p_bad, p_acc);
    end
  endtask

  task automatic test_poll_timeout;
    bit   ok;
    obs_t o;
    m_hold_trdy = 1'b1;
    exp_q.push_back('{24'h000000, 0});
    send_word(24'h00FF01, ok);
    wait_idle(3000, ok);
    m_hold_trdy = 1'b0;
    n_checks++;
    if (!ok || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: idle=%b err=%b, expected 1/1", ok, err);
    end
    n_checks++;
    if (obs_q.size() == 0) begin
      n_fail++;
      $display("FAIL timeout_frame: got no SS release, expected one");
    end else begin
      o = obs_q.pop_front();
      if (o.nbytes != exp_q[0].nbytes || o.reads != PollLim) begin
        n_fail++;
        $display("FAIL timeout_frame: got %0d bytes/%0d reads, expected %0d/%0d",
                 o.nbytes, o.reads, exp_q[0].nbytes, PollLim);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    bit   ok;
    int   overlap;
    exp_t e;
    obs_t o;
    exp_q.push_back('{24'h000001, 3});
    exp_q.push_back('{24'h123456, 3});
    overlap = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 24'h000001;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 3000; i++) begin
        if (cmd_ready) begin
          overlap++;
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready_drop: got %b, expected 0", cmd_ready);
      end
      cmd_data = 24'h123456;
    end
    cmd_valid = 1'b0;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok || overlap != 2) begin
      n_fail++;
      $display("FAIL b2b_overlap: idle=%b overlaps=%0d, expected 1/2", ok, overlap);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_frame: got none, expected %06h", e.word);
      end else begin
        o = obs_q.pop_front();
        if (o.word !== e.word || o.nbytes != e.nbytes) begin
          n_fail++;
          $display("FAIL b2b_frame: got %06h/%0d bytes, expected %06h/%0d",
                   o.word, o.nbytes, e.word, e.nbytes);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_extra: extra=%0d err=%b, expected 0/1", obs_q.size(), err);
    end
  endtask

  task automatic test_reset_mid_word;
    bit ok;
    send_word(24'hC3A511, ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_sso && m_nbytes == 2) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset_wait: 2nd byte not seen, expected it");
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy, init_done, err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b, expected 0100", {cmd_ready, busy, init_done, err});
    end
    n_checks++;
    if ({spi_select, write_n, read_n, mem_addr, data_from_cpu} !== {3'b011, 3'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset_bus: got %b/%b/%b/%h/%h, expected 0/1/1/0/0000",
               spi_select, write_n, read_n, mem_addr, data_from_cpu);
    end
    exp_q.delete();
    obs_q.delete();
    push_init();
    @(negedge clk);
    reset_n = 1'b1;
    test_init("reinit");
  endtask

  initial begin
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    cmd_valid2  = 1'b0;
    cmd_data2   = '0;
    m_hold_trdy = 1'b0;
    test_reset();
    push_init();
    @(negedge clk);
    reset_n = 1'b1;
    test_init("init");
    test_no_init();
    test_host_words();
    test_poll_timeout();
    test_back_to_back();
    test_reset_mid_word();
    n_checks++;
    if (p_bad != 0) begin
      n_fail++;
      $display("FAIL bus_protocol_final: bad=%0d, expected 0", p_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
